astar_open_list: RTL and testbench
==================================

Name: astar_open_list

Overview:
- Downstream consumer of the Euclidean-distance accelerator results in the A* pipeline.
- Holds the A* open set as a register-based priority queue of {node key, cost} entries, always sorted by ascending cost.
- Accepts pushes of newly scored nodes, with decrease-key on duplicates.
- Presents the minimum-cost entry at its head for the expansion stage to pop.

Parameters:
- DEPTH, 16, number of entry slots (power of two, 4..64).
- KEY_W, 16, node identifier width.
- COST_W, 32, cost width; matches the 32-bit distance result word. Compared unsigned.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of all entries.
- push_valid  in  1  push request.
- push_ready  out  1  push accepted when valid&&ready; equals !full.
- push_key  in  KEY_W  node id to insert or update.
- push_cost  in  COST_W  cost of that node.
- pop_valid  out  1  head entry present; equals !empty.
- pop_ready  in  1  consumer takes head when valid&&ready.
- pop_key  out  KEY_W  key of minimum-cost entry.
- pop_cost  out  COST_W  cost of minimum-cost entry.
- count  out  $clog2(DEPTH)+1  number of occupied slots.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- upd_pulse  out  1  one-cycle pulse: last accepted push hit an existing key and lowered its cost.

Behaviour:
- Reset (rst high, asynchronous):
  - All slot valid bits 0, slot data 0.
  - count=0, empty=1, full=0, pop_valid=0, pop_key=0, pop_cost=0, push_ready=1, upd_pulse=0.
  - Reset mid-operation discards all contents; no partial updates survive.
- Storage:
  - Slot array is registered; slot[0] is always the head.
  - pop_key/pop_cost come directly from slot[0] registers; no combinational path from push inputs.
- Ordering:
  - Ascending cost.
  - Equal costs keep arrival order: the new entry goes after all existing entries with cost <= push_cost.
- One operation set per cycle. Priority: clear > (pop, push) evaluated together.
- Pop only (accepted): slots shift toward head by one; count-1. Result visible next cycle.
- Push of a new key (no valid slot holds push_key):
  - Insert at the ordered position; later slots shift tail-ward.
  - count+1. Visible at head next cycle if it is the new minimum.
- Push of an existing key:
  - push_cost < stored cost: remove old slot and insert new at the ordered position in the same cycle. count unchanged; upd_pulse=1 next cycle.
  - push_cost >= stored cost: push is accepted and discarded. Contents and count unchanged; upd_pulse=0.
- Simultaneous pop and push:
  - The head is removed first (pre-cycle contents); the push is then applied to the remaining entries.
  - If push_key equals the key being popped, treat it as a new-key insert.
  - Net count is unchanged for a new key, or -1 for a discarded duplicate, or -1 for an updated duplicate.
- Full:
  - push_ready=0, even if push_key matches an existing entry, or a pop happens the same cycle.
  - push_valid while full is ignored; the push must be held by the producer.
- Empty: pop_valid=0; pop_ready is ignored.
- Clear: next cycle equals the reset state (except it is synchronous). Any simultaneous push/pop is dropped.
- Key match compares only valid slots; at most one slot per key is invariant.

Decomposition:
- astar_pkg:
  - pq_entry_t struct {logic valid; logic [KEY_W-1:0] key; logic [COST_W-1:0] cost;}.
  - Default DEPTH/KEY_W/COST_W localparams.
  - Cost compare function (unsigned less-or-equal).
- Sub-module pq_slot: one slot register plus its next-value mux.
  - Choices: hold, shift from upper neighbour, shift from lower neighbour, load push entry, clear.
  - Driven by per-slot compare/match vectors generated in the top.

Test Plan:
- Reset then push (key 5,cost 30),(7,10),(9,20) -> head (7,10); pops return 7,9,5; empty=1 after third pop.
- Push (1,50),(2,50),(3,50) -> pops in order 1,2,3 (tie FIFO); count goes 3->0.
- Queue {(4,40),(6,60)}, push (6,15) -> head (6,15), count=2, upd_pulse one cycle; then push (6,99) -> no change, upd_pulse=0.
- Fill to DEPTH=16 with costs 16..1 -> full=1, push_ready=0, head cost 1; held push completes only after a pop frees a slot.
- Queue {(3,5),(8,9)}, same-cycle pop and push (3,7) -> popped (3,5), next contents {(3,7),(8,9)}, count=2.
- Mid-fill assert clear with push_valid=1 -> next cycle count=0, empty=1, pushed entry absent. Assert rst asynchronously mid-pop -> outputs zero immediately.

Source files
------------

// File: rtl/astar_pkg.sv
// rtl/astar_pkg.sv - shared types, default sizes and cost compare for the A* open list
package astar_pkg;

   localparam int PQ_DEPTH  = 16;
   localparam int PQ_KEY_W  = 16;
   localparam int PQ_COST_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [PQ_KEY_W-1:0]  key;
      logic [PQ_COST_W-1:0] cost;
   } pq_entry_t;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_UP,
      SEL_DN,
      SEL_LOAD,
      SEL_CLR
   } slot_sel_e;

   function automatic logic cost_le(input logic [PQ_COST_W-1:0] a,
                                    input logic [PQ_COST_W-1:0] b);
      return a <= b;
   endfunction

endpackage

// File: rtl/pq_slot.sv
// rtl/pq_slot.sv - one priority-queue slot register with its next-value mux
module pq_slot
   import astar_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  slot_sel_e sel_i,
   input  pq_entry_t up_i,
   input  pq_entry_t dn_i,
   input  pq_entry_t load_i,
   output pq_entry_t q_o
);

   pq_entry_t entry_q;
   pq_entry_t entry_d;

   always_comb begin
      entry_d = entry_q;
      case (sel_i)
         SEL_UP:   entry_d = up_i;
         SEL_DN:   entry_d = dn_i;
         SEL_LOAD: entry_d = load_i;
         SEL_CLR:  entry_d = '0;
         default:  entry_d = entry_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_q <= '0;
      else     entry_q <= entry_d;
   end

   assign q_o = entry_q;

endmodule

// File: rtl/astar_open_list.sv
// rtl/astar_open_list.sv - register-based sorted open set with decrease-key for the A* pipeline
module astar_open_list
   import astar_pkg::*;
#(
   parameter int DEPTH  = PQ_DEPTH,
   parameter int KEY_W  = PQ_KEY_W,
   parameter int COST_W = PQ_COST_W,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push_valid,
   output logic              push_ready,
   input  logic [KEY_W-1:0]  push_key,
   input  logic [COST_W-1:0] push_cost,
   output logic              pop_valid,
   input  logic              pop_ready,
   output logic [KEY_W-1:0]  pop_key,
   output logic [COST_W-1:0] pop_cost,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              upd_pulse
);

   pq_entry_t        slot_q [DEPTH];
   pq_entry_t        eff    [DEPTH];
   pq_entry_t        push_ent;
   logic [DEPTH-1:0] match;
   logic [DEPTH-1:0] le;
   logic [COST_W-1:0] hit_cost;
   logic             pop_acc, push_acc, hit, upd, ins;
   logic [CNT_W-1:0] count_q, count_d;
   logic             upd_pulse_q, upd_pulse_d;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   assign pop_acc    = !empty && pop_ready;
   assign push_acc   = push_valid && !full;
   assign push_ent   = '{valid: 1'b1, key: push_key, cost: push_cost};

   // Duplicate keys are unique among valid slots, so an OR-reduce picks the hit cost.
   always_comb begin
      hit_cost = '0;
      for (int i = 0; i < DEPTH; i++)
         if (match[i]) hit_cost = hit_cost | eff[i].cost;
   end

   assign hit = |match;
   assign upd = push_acc && hit && !cost_le(hit_cost, push_cost);
   assign ins = push_acc && (!hit || upd);

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      pq_entry_t up_n, dn_n;
      logic      prev_le, pre_match, take_prev, take_new;
      slot_sel_e sel;

      if (g == DEPTH - 1) begin : g_top
         assign up_n = '0;
      end else begin : g_mid_up
         assign up_n = slot_q[g+1];
      end

      if (g == 0) begin : g_head
         assign dn_n      = '0;
         assign prev_le   = 1'b1;
         assign pre_match = 1'b0;
      end else begin : g_mid_dn
         assign dn_n      = slot_q[g-1];
         assign prev_le   = le[g-1];
         assign pre_match = |match[g-1:0];
      end

      // eff is the queue as seen after any accepted pop; the push works on it.
      assign eff[g]   = pop_acc ? up_n : slot_q[g];
      assign match[g] = eff[g].valid && (eff[g].key == push_key);
      assign le[g]    = eff[g].valid && cost_le(eff[g].cost, push_cost);

      // le is a prefix mask, so the first clear bit is the insert position.
      always_comb begin
         take_new  = 1'b0;
         take_prev = 1'b0;
         if (ins && !le[g]) begin
            if (prev_le) take_new  = 1'b1;
            else         take_prev = upd ? !pre_match : 1'b1;
         end
      end

      always_comb begin
         sel = SEL_HOLD;
         if (clear)          sel = SEL_CLR;
         else if (take_new)  sel = SEL_LOAD;
         else if (take_prev) sel = pop_acc ? SEL_HOLD : SEL_DN;
         else if (pop_acc)   sel = SEL_UP;
      end

      pq_slot u_slot (
         .clk    (clk),
         .rst    (rst),
         .sel_i  (sel),
         .up_i   (up_n),
         .dn_i   (dn_n),
         .load_i (push_ent),
         .q_o    (slot_q[g])
      );
   end

   always_comb begin
      count_d     = count_q;
      upd_pulse_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else begin
         if (pop_acc)     count_d = count_d - CNT_W'(1);
         if (ins && !upd) count_d = count_d + CNT_W'(1);
         upd_pulse_d = upd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         upd_pulse_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         upd_pulse_q <= upd_pulse_d;
      end
   end

   assign count      = count_q;
   assign upd_pulse  = upd_pulse_q;
   assign push_ready = !full;
   assign pop_valid  = !empty;
   assign pop_key    = slot_q[0].key;
   assign pop_cost   = slot_q[0].cost;

endmodule

// File: tb/tb_astar_open_list.sv
// tb/tb_astar_open_list.sv - directed bench with a queue model of the sorted open set
module tb_astar_open_list;
   localparam int DEPTH  = 16;
   localparam int KEY_W  = 16;
   localparam int COST_W = 32;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              push_valid = 1'b0;
   logic              pop_ready = 1'b0;
   logic [KEY_W-1:0]  push_key = '0;
   logic [COST_W-1:0] push_cost = '0;
   logic              push_ready, pop_valid, full, empty, upd_pulse;
   logic [KEY_W-1:0]  pop_key;
   logic [COST_W-1:0] pop_cost;
   logic [CNT_W-1:0]  count;

   typedef struct {
      logic [KEY_W-1:0]  key;
      logic [COST_W-1:0] cost;
   } ment_t;

   ment_t mq[$];
   logic  m_upd = 1'b0;
   int    checks = 0;
   int    failures = 0;

   astar_open_list dut (
      .clk(clk), .rst(rst), .clear(clear),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_key(push_key), .push_cost(push_cost),
      .pop_valid(pop_valid), .pop_ready(pop_ready),
      .pop_key(pop_key), .pop_cost(pop_cost),
      .count(count), .full(full), .empty(empty), .upd_pulse(upd_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_apply(input logic pv, input logic [KEY_W-1:0] k,
                              input logic [COST_W-1:0] c, input logic pr, input logic clr);
      int idx;
      int pos;
      logic pacc;
      ment_t e;
      m_upd = 1'b0;
      if (clr) begin
         mq.delete();
         return;
      end
      pacc = pv && (mq.size() < DEPTH);
      if (pr && mq.size() > 0) void'(mq.pop_front());
      if (!pacc) return;
      idx = -1;
      foreach (mq[i]) if (mq[i].key == k) idx = i;
      if (idx >= 0) begin
         if (c >= mq[idx].cost) return;
         mq.delete(idx);
         m_upd = 1'b1;
      end
      pos = 0;
      while (pos < mq.size() && mq[pos].cost <= c) pos++;
      e.key  = k;
      e.cost = c;
      mq.insert(pos, e);
   endtask

   task automatic step(input logic pv, input logic [KEY_W-1:0] k,
                       input logic [COST_W-1:0] c, input logic pr, input logic clr);
      push_valid = pv;
      push_key   = k;
      push_cost  = c;
      pop_ready  = pr;
      clear      = clr;
      @(posedge clk);
      model_apply(pv, k, c, pr, clr);
      #1;
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic push(input logic [KEY_W-1:0] k, input logic [COST_W-1:0] c);
      step(1'b1, k, c, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   task automatic head_is(input string name, input logic [KEY_W-1:0] k,
                          input logic [COST_W-1:0] c, input int n);
      chk({name, "_key"}, pop_key, k);
      chk({name, "_cost"}, pop_cost, c);
      chk({name, "_count"}, count, n);
   endtask

   always @(negedge clk) begin
      chk("m_count", count, mq.size());
      chk("m_empty", empty, mq.size() == 0);
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_push_ready", push_ready, mq.size() != DEPTH);
      chk("m_pop_valid", pop_valid, mq.size() != 0);
      chk("m_pop_key", pop_key, (mq.size() != 0) ? mq[0].key : '0);
      chk("m_pop_cost", pop_cost, (mq.size() != 0) ? mq[0].cost : '0);
      chk("m_upd_pulse", upd_pulse, m_upd);
   end

   initial begin
      #12;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_push_ready", push_ready, 1);
      chk("rst_pop_valid", pop_valid, 0);
      chk("rst_pop_key", pop_key, 0);
      chk("rst_upd", upd_pulse, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      push(5, 30); push(7, 10); push(9, 20);
      head_is("t1_head", 7, 10, 3);
      pop(); head_is("t1_pop1", 9, 20, 2);
      pop(); head_is("t1_pop2", 5, 30, 1);
      pop(); chk("t1_empty", empty, 1);

      push(1, 50); push(2, 50); push(3, 50);
      head_is("t2_head", 1, 50, 3);
      pop(); head_is("t2_pop1", 2, 50, 2);
      pop(); head_is("t2_pop2", 3, 50, 1);
      pop(); chk("t2_count", count, 0);

      push(4, 40); push(6, 60);
      push(6, 15);
      head_is("t3_upd", 6, 15, 2);
      chk("t3_pulse", upd_pulse, 1);
      push(6, 99);
      head_is("t3_keep", 6, 15, 2);
      chk("t3_nopulse", upd_pulse, 0);
      pop(); pop();

      for (int i = 0; i < DEPTH; i++) push(KEY_W'(100 + i), COST_W'(16 - i));
      chk("t4_full", full, 1);
      chk("t4_ready", push_ready, 0);
      head_is("t4_head", 115, 1, 16);
      for (int i = 0; i < 3; i++) push(200, 0);
      head_is("t4_held", 115, 1, 16);
      step(1'b1, 200, 0, 1'b1, 1'b0);
      head_is("t4_popfull", 114, 2, 15);
      push(200, 0);
      head_is("t4_late", 200, 0, 16);
      for (int i = 0; i < DEPTH; i++) pop();
      chk("t4_drained", empty, 1);

      push(3, 5); push(8, 9);
      head_is("t5_pre", 3, 5, 2);
      step(1'b1, 3, 7, 1'b1, 1'b0);
      head_is("t5_post", 3, 7, 2);
      chk("t5_pulse", upd_pulse, 0);
      pop(); head_is("t5_next", 8, 9, 1);
      pop();

      push(1, 5); push(2, 9); push(4, 20);
      step(1'b1, 4, 6, 1'b1, 1'b0);
      head_is("t6_upd", 4, 6, 2);
      chk("t6_pulse", upd_pulse, 1);
      pop(); head_is("t6_next", 2, 9, 1);
      pop();

      push(10, 3); push(11, 4);
      step(1'b1, 12, 1, 1'b1, 1'b1);
      head_is("t7_clear", 0, 0, 0);
      chk("t7_empty", empty, 1);
      push(12, 8);
      head_is("t7_after", 12, 8, 1);
      pop();

      push(5, 30); push(7, 10);
      pop_ready = 1'b1;
      @(posedge clk);
      model_apply(1'b0, '0, '0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      mq.delete();
      m_upd = 1'b0;
      #1;
      chk("t8_count", count, 0);
      chk("t8_pop_valid", pop_valid, 0);
      chk("t8_pop_key", pop_key, 0);
      chk("t8_pop_cost", pop_cost, 0);
      chk("t8_push_ready", push_ready, 1);
      pop_ready = 1'b0;
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push(21, 2);
      head_is("t8_recover", 21, 2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
